// File: rtl/pll_ce_gen.sv
// Multi-channel fractional clock-enable generator gated by a qualified PLL lock.
// Each channel's phase accumulator overflow becomes a single-cycle enable pulse.
module pll_ce_gen #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned LOCK_CYCLES = 1024,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              cfg_clr,
  output logic [NUM_CH-1:0] ce_out,
  output logic              ready
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES);

  typedef enum logic {
    WAIT_LOCK,
    RUN
  } state_t;

  state_t state, state_nxt;

  logic             lk_meta;
  logic             lk_s;
  logic [CNT_W-1:0] lock_cnt;
  logic             lock_done;
  logic             run_acc;

  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W-1:0] inc [NUM_CH];
  logic [ACC_W:0]   sum [NUM_CH];

  always_ff @(posedge refclk) begin
    if (rst) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) state <= WAIT_LOCK;
    else     state <= state_nxt;
  end

  always_comb begin
    lock_done = lk_s && (lock_cnt == CNT_W'(LOCK_CYCLES - 1));
    state_nxt = state;
    case (state)
      WAIT_LOCK: if (lock_done) state_nxt = RUN;
      RUN:       if (!lk_s)     state_nxt = WAIT_LOCK;
      default:                  state_nxt = WAIT_LOCK;
    endcase
  end

  // Losing lock in RUN blocks the accumulate on the same edge the state drops.
  always_comb begin
    ready   = (state == RUN);
    run_acc = (state == RUN) && lk_s;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_cnt <= '0;
    end else if (state == WAIT_LOCK) begin
      if (!lk_s || lock_done) lock_cnt <= '0;
      else                    lock_cnt <= lock_cnt + CNT_W'(1);
    end else if (!lk_s) begin
      lock_cnt <= '0;
    end
  end

  always_ff @(posedge refclk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rst)                                 inc[i] <= '0;
      else if (cfg_we && cfg_ch == CH_W'(i))   inc[i] <= cfg_inc;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
    end
  end

  // The carry out of the ACC_W+1 bit sum is the enable pulse for that channel.
  always_ff @(posedge refclk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rst || cfg_clr || !run_acc) begin
        acc[i]    <= '0;
        ce_out[i] <= 1'b0;
      end else begin
        acc[i]    <= sum[i][ACC_W-1:0];
        ce_out[i] <= sum[i][ACC_W];
      end
    end
  end

endmodule
